// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor.
// Processes DIGIT bits per clock, LSB first, through a single registered carry.
// Handshake: start (sampled when not busy) -> busy for NDIG cycles -> one-cycle done.
// Outputs sum/cout/ovf are registered and change only on completion or reset.
module serial_addsub #(
  parameter int WIDTH = 16,  // operand/result width, >= 2
  parameter int DIGIT = 1    // bits per clock, must divide WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   dig_sum;
  logic [WIDTH-1:0] dig_ext;
  logic [WIDTH-1:0] res_next;
  logic             last_dig;
  logic             msb_cin;

  // Digit adder and result assembly for the current RUN cycle
  always_comb begin
    dig_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
             + {{DIGIT{1'b0}}, carry_q};
    dig_ext  = '0;
    dig_ext[DIGIT-1:0] = dig_sum[DIGIT-1:0];
    // New digit enters at the MSB end; after NDIG shifts it is fully aligned
    res_next = (res_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
    last_dig = (cnt_q == CW'(NDIG - 1));
    // Carry into the top bit recovered from that bit's own sum: s = a ^ b ^ cin
    msb_cin  = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_sum[DIGIT-1];
  end

  // Next-state and next-output computation for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction as a + ~b + 1: invert B and seed the carry with 1
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          res_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_sum[DIGIT];
        res_d   = res_next;
        cnt_d   = cnt_q + CW'(1);
        if (last_dig) begin
          sum_d   = res_next;
          cout_d  = dig_sum[DIGIT];
          ovf_d   = msb_cin ^ dig_sum[DIGIT];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset discards any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: an 8-bit/1-bit-digit and a 16-bit/4-bit-digit
// instance driven by directed steps; expected results queued at start and
// compared when done pulses.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb8[$];
  exp_t sb16[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_busy(input bit w16);
    return w16 ? busy16 : busy8;
  endfunction
  function automatic logic o_done(input bit w16);
    return w16 ? done16 : done8;
  endfunction
  function automatic logic [15:0] o_sum(input bit w16);
    return w16 ? sum16 : {8'h00, sum8};
  endfunction
  function automatic logic o_cout(input bit w16);
    return w16 ? cout16 : cout8;
  endfunction
  function automatic logic o_ovf(input bit w16);
    return w16 ? ovf16 : ovf8;
  endfunction

  // Reference: wide add of a + (sub ? ~b : b) + sub, signed overflow from operand/result signs
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input bit sub);
    exp_t        e;
    logic [16:0] mask;
    logic [15:0] am, bm;
    logic [16:0] full;
    mask = (17'd1 << w) - 17'd1;
    am   = a & mask[15:0];
    bm   = (sub ? ~b : b) & mask[15:0];
    full = {1'b0, am} + {1'b0, bm} + {16'd0, sub};
    e.sum  = full[15:0] & mask[15:0];
    e.cout = full[w];
    e.ovf  = (am[w-1] == bm[w-1]) && (e.sum[w-1] != am[w-1]);
    return e;
  endfunction

  // Drive start for one edge, queue the expectation, then scramble the operands
  task automatic launch(input bit w16, input logic [15:0] a, input logic [15:0] b,
                        input bit sub, input bit push);
    exp_t e;
    e = model(w16 ? 16 : 8, a, b, sub);
    if (w16) begin
      a16 = a; b16 = b; sub16 = sub; start16 = 1'b1;
      if (push) sb16.push_back(e);
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; start8 = 1'b1;
      if (push) sb8.push_back(e);
    end
    tick;
    if (w16) begin
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
    end else begin
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    end
    chk("busy_after_start", {15'd0, o_busy(w16)}, 16'd1);
    chk("done_after_start", {15'd0, o_done(w16)}, 16'd0);
  endtask

  // Wait (bounded) for done; check latency, busy duration and queued result
  task automatic finish(input bit w16, input int edges0, input string tag);
    int   edges;
    int   busy_n;
    int   ndig;
    exp_t e;
    edges  = edges0;
    busy_n = 0;
    ndig   = w16 ? 4 : 8;
    while (!o_done(w16) && edges < 40) begin
      if (o_busy(w16)) busy_n++;
      tick;
      edges++;
    end
    chk({tag, "_latency"}, 16'(edges), 16'(ndig + 1));
    chk({tag, "_busy_cycles"}, 16'(busy_n), 16'(ndig - (edges0 - 1)));
    chk({tag, "_busy_at_done"}, {15'd0, o_busy(w16)}, 16'd0);
    if ((w16 ? sb16.size() : sb8.size()) == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = w16 ? sb16.pop_front() : sb8.pop_front();
      chk({tag, "_sum"}, o_sum(w16), e.sum);
      chk({tag, "_cout"}, {15'd0, o_cout(w16)}, {15'd0, e.cout});
      chk({tag, "_ovf"}, {15'd0, o_ovf(w16)}, {15'd0, e.ovf});
    end
  endtask

  task automatic idle_after(input bit w16, input string tag);
    tick;
    chk({tag, "_done_one_cycle"}, {15'd0, o_done(w16)}, 16'd0);
    chk({tag, "_idle_busy"}, {15'd0, o_busy(w16)}, 16'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    tick;
    tick;
    for (int w = 0; w < 2; w++) begin
      chk("rst_busy", {15'd0, o_busy(w[0])}, 16'd0);
      chk("rst_done", {15'd0, o_done(w[0])}, 16'd0);
      chk("rst_sum", o_sum(w[0]), 16'd0);
      chk("rst_cout", {15'd0, o_cout(w[0])}, 16'd0);
      chk("rst_ovf", {15'd0, o_ovf(w[0])}, 16'd0);
    end
    rst = 1'b0;
    tick;

    // Signed overflow on 0x7F + 0x01
    launch(1'b0, 16'h7F, 16'h01, 1'b0, 1'b1);
    finish(1'b0, 1, "add_7f_01");
    idle_after(1'b0, "add_7f_01");

    // Unsigned carry-out, then borrow
    launch(1'b0, 16'hFF, 16'h01, 1'b0, 1'b1);
    finish(1'b0, 1, "add_ff_01");
    idle_after(1'b0, "add_ff_01");
    launch(1'b0, 16'h00, 16'h01, 1'b1, 1'b1);
    finish(1'b0, 1, "sub_00_01");
    idle_after(1'b0, "sub_00_01");

    // Subtract with signed overflow, then back-to-back start in the done cycle
    launch(1'b0, 16'h80, 16'h01, 1'b1, 1'b1);
    finish(1'b0, 1, "sub_80_01");
    launch(1'b0, 16'h05, 16'h03, 1'b0, 1'b1);
    finish(1'b0, 1, "b2b_05_03");
    idle_after(1'b0, "b2b_05_03");

    // Wide digits
    launch(1'b1, 16'h1234, 16'hEDCC, 1'b0, 1'b1);
    finish(1'b1, 1, "w16_1234_edcc");
    idle_after(1'b1, "w16_1234_edcc");

    // start re-asserted mid-RUN with other operands is ignored
    launch(1'b0, 16'h3C, 16'h15, 1'b1, 1'b1);
    tick;
    tick;
    a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    finish(1'b0, 4, "midrun8");
    idle_after(1'b0, "midrun8");
    launch(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1);
    tick;
    a16 = 16'h0F0F; b16 = 16'h1111; sub16 = 1'b0; start16 = 1'b1;
    tick;
    start16 = 1'b0;
    finish(1'b1, 3, "midrun16");
    idle_after(1'b1, "midrun16");

    // Reset in the third RUN cycle discards the operation
    launch(1'b0, 16'h11, 16'h22, 1'b0, 1'b0);
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_busy", {15'd0, busy8}, 16'd0);
    chk("midrst_done", {15'd0, done8}, 16'd0);
    chk("midrst_sum", {8'd0, sum8}, 16'd0);
    chk("midrst_cout", {15'd0, cout8}, 16'd0);
    chk("midrst_ovf", {15'd0, ovf8}, 16'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done8) seen++;
    end
    chk("midrst_no_done", 16'(seen), 16'd0);
    launch(1'b0, 16'h64, 16'h9C, 1'b1, 1'b1);
    finish(1'b0, 1, "after_rst");
    idle_after(1'b0, "after_rst");

    // Random operands on both instances
    for (int i = 0; i < 6; i++) begin
      launch(1'b0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
             1'($urandom), 1'b1);
      finish(1'b0, 1, "rand8");
      launch(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      finish(1'b1, 1, "rand16");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
